// File: rtl/arb_pkg.sv
// arb_pkg: shared types and defaults for the imem/dmem arbiter
package arb_pkg;
  localparam int DEF_ADDR_W = 64;
  localparam int DEF_DATA_W = 64;
  typedef enum logic {IDLE, WAIT} state_t;
  typedef enum logic {OWNER_F = 1'b0, OWNER_D = 1'b1} owner_t;
  function automatic logic misaligned(input logic [2:0] lsb);
    return |lsb;
  endfunction
endpackage

// File: rtl/arb_pick.sv
// arb_pick: D-priority winner select with starvation counter for F
module arb_pick
  import arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   en_i,
  input  logic   f_req_i,
  input  logic   d_req_i,
  output logic   grant_o,
  output owner_t winner_o
);
  logic [3:0] starve_q, starve_d;
  // F wins only when D is absent or F has waited MAX_WAIT D grants; starve_cnt saturates
  always_comb begin
    grant_o  = en_i && (f_req_i || d_req_i);
    winner_o = (d_req_i && !(f_req_i && starve_q == 4'(MAX_WAIT))) ? OWNER_D : OWNER_F;
    starve_d = !f_req_i ? '0 :
               !grant_o ? starve_q :
               winner_o == OWNER_F ? '0 :
               &starve_q ? starve_q : starve_q + 4'd1;
  end
  // starvation counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) starve_q <= '0;
    else starve_q <= starve_d;
  end
endmodule

// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: shares one memory port between fetch (F) and load/store (D)
module imem_dmem_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = 4,
  parameter int TIMEOUT  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              f_req_i,
  input  logic [ADDR_W-1:0] f_addr_i,
  output logic              f_gnt_o,
  output logic              f_rvalid_o,
  output logic [DATA_W-1:0] f_rdata_o,
  output logic              f_err_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);
  state_t            state_q, state_d;
  owner_t            owner_q, owner_d, winner;
  logic              store_q, store_d;
  logic [7:0]        tmo_q, tmo_d;
  logic              f_gnt_q, f_gnt_d, f_rvalid_q, f_rvalid_d, f_err_q, f_err_d;
  logic              d_gnt_q, d_gnt_d, d_rvalid_q, d_rvalid_d, d_err_q, d_err_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [DATA_W-1:0] f_rdata_q, f_rdata_d, d_rdata_q, d_rdata_d, mem_wdata_q, mem_wdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              grant, pick_d, mis, rsp, done;
  logic [DATA_W-1:0] rsp_data;

  arb_pick #(.MAX_WAIT(MAX_WAIT)) u_pick (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .en_i     (state_q == IDLE),
    .f_req_i  (f_req_i),
    .d_req_i  (d_req_i),
    .grant_o  (grant),
    .winner_o (winner)
  );

  assign pick_d   = winner == OWNER_D;
  assign mis      = misaligned(pick_d ? d_addr_i[2:0] : f_addr_i[2:0]);
  assign rsp      = mem_rvalid_i && !mem_req_q;
  assign done     = rsp || tmo_q == 8'(TIMEOUT - 1);
  assign rsp_data = (rsp && !store_q) ? mem_rdata_i : '0;

  assign f_gnt_o     = f_gnt_q;
  assign f_rvalid_o  = f_rvalid_q;
  assign f_rdata_o   = f_rdata_q;
  assign f_err_o     = f_err_q;
  assign d_gnt_o     = d_gnt_q;
  assign d_rvalid_o  = d_rvalid_q;
  assign d_rdata_o   = d_rdata_q;
  assign d_err_o     = d_err_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

  // next state: grant/issue in IDLE, completion or timeout routing in WAIT
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    store_d     = store_q;
    tmo_d       = tmo_q;
    f_gnt_d     = 1'b0;
    f_rvalid_d  = 1'b0;
    f_rdata_d   = f_rdata_q;
    f_err_d     = f_err_q;
    d_gnt_d     = 1'b0;
    d_rvalid_d  = 1'b0;
    d_rdata_d   = d_rdata_q;
    d_err_d     = d_err_q;
    mem_req_d   = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (state_q == IDLE && grant) begin
      f_gnt_d = !pick_d;
      d_gnt_d = pick_d;
      if (mis) begin
        f_rvalid_d = !pick_d;
        d_rvalid_d = pick_d;
        f_err_d    = pick_d ? f_err_q : 1'b1;
        f_rdata_d  = pick_d ? f_rdata_q : '0;
        d_err_d    = pick_d ? 1'b1 : d_err_q;
        d_rdata_d  = pick_d ? '0 : d_rdata_q;
      end else begin
        mem_req_d   = 1'b1;
        mem_we_d    = pick_d && d_we_i;
        mem_addr_d  = pick_d ? d_addr_i : f_addr_i;
        mem_wdata_d = pick_d ? d_wdata_i : '0;
        owner_d     = winner;
        store_d     = pick_d && d_we_i;
        tmo_d       = '0;
        state_d     = WAIT;
      end
    end else if (state_q == WAIT) begin
      tmo_d = tmo_q + 8'd1;
      if (done) begin
        state_d = IDLE;
        if (owner_q == OWNER_D) begin
          d_rvalid_d = 1'b1;
          d_err_d    = !rsp;
          d_rdata_d  = rsp_data;
        end else begin
          f_rvalid_d = 1'b1;
          f_err_d    = !rsp;
          f_rdata_d  = rsp_data;
        end
      end
    end
  end

  // all state and outputs registered; reset abandons any outstanding access
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      owner_q     <= OWNER_F;
      store_q     <= 1'b0;
      tmo_q       <= '0;
      f_gnt_q     <= 1'b0;
      f_rvalid_q  <= 1'b0;
      f_rdata_q   <= '0;
      f_err_q     <= 1'b0;
      d_gnt_q     <= 1'b0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= '0;
      d_err_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      store_q     <= store_d;
      tmo_q       <= tmo_d;
      f_gnt_q     <= f_gnt_d;
      f_rvalid_q  <= f_rvalid_d;
      f_rdata_q   <= f_rdata_d;
      f_err_q     <= f_err_d;
      d_gnt_q     <= d_gnt_d;
      d_rvalid_q  <= d_rvalid_d;
      d_rdata_q   <= d_rdata_d;
      d_err_q     <= d_err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end
endmodule
